l1_rate_servo_wb_master: RTL
============================

// Module: l1_rate_servo_wb_master
// PURPOSE
//  Wishbone initiator that closes the L1 trigger-rate loop. Once per sample period it reads each beam's
//  trigger count from the L1 trigger target and computes a proportional threshold correction per beam.
//  It writes the new thresholds back, then issues one threshold-update strobe.
//  Sits in the PS-clock slow-control domain, driving the L1 trigger wrapper's WB target port.
// PARAMETERS
//  NBEAMS          2          beams serviced per sweep (1..256)
//  PERIOD_CLOCKS   100000000  wb_clk_i cycles from one sweep start to the next
//  TIMEOUT_CLOCKS  255        max cycles waiting for ack/err/rty before abort
//  NFRAC_KP        10         fractional bits of kp_i
//  START_THRESH    18'h3FFFF  per-beam threshold after reset
//  COUNT_BASE      22'h000100 count read address = COUNT_BASE + beam
//  THRESH_BASE     22'h000100 threshold write address = THRESH_BASE + beam
//  UPDATE_ADDR     22'h000000 update-strobe write address
// PORTS
//  wb_clk_i     in   1   only clock
//  wb_rst_n_i   in   1   async active-low reset
//  enable_i     in   1   1 = run sweeps; sampled only in IDLE
//  target_i     in   32  target trigger count per period (unsigned)
//  kp_i         in   32  proportional gain, unsigned, NFRAC_KP fractional bits
//  wb_cyc_o     out  1   WB cycle
//  wb_stb_o     out  1   WB strobe
//  wb_we_o      out  1   WB write enable
//  wb_adr_o     out  22  WB address
//  wb_dat_o     out  32  WB write data
//  wb_sel_o     out  4   WB byte select, always 4'hF
//  wb_ack_i     in   1   WB acknowledge
//  wb_err_i     in   1   WB error
//  wb_rty_i     in   1   WB retry
//  wb_dat_i     in   32  WB read data
//  busy_o       out  1   sweep in progress
//  err_o        out  1   sticky: a transaction errored or timed out; cleared by enable_i=0
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0, state IDLE, thresholds = START_THRESH,
//   period and timeout counters 0.
//  Single classic-cycle bus: cyc_o=stb_o=1, adr/we/dat held stable until ack/err/rty or timeout.
//   Both drop to 0 the cycle after termination. Next request is at least 1 idle cycle later.
//  FSM: IDLE -> (enable_i) WAIT -> RD -> CALC -> WR -> next beam RD ... after last beam UPD -> WAIT.
//  Period counter runs in WAIT and throughout the sweep. A sweep starts every PERIOD_CLOCKS cycles.
//   If a sweep overruns the period, the next sweep starts immediately on return to WAIT; periods are never queued.
//  RD: we=0, adr=COUNT_BASE+beam. On ack, latch wb_dat_i as count.
//  CALC (1 cycle): err = $signed({1'b0,count}) - $signed({1'b0,target_i}) (33b).
//   delta = (err * $signed({1'b0,kp_i})) >>> NFRAC_KP (66b product, arithmetic shift).
//   new = thresh[beam] + delta; saturate to [0, 2^18-1]. Positive error raises the threshold.
//  WR: we=1, adr=THRESH_BASE+beam, dat={14'b0,new}. thresh[beam] updates on ack only.
//  UPD: we=1, adr=UPDATE_ADDR, dat=32'h1.
//  wb_rty_i: drop cyc, wait 1 cycle, reissue the identical transaction; retry count is unlimited.
//   Each reissue restarts the timeout.
//  wb_err_i or timeout (TIMEOUT_CLOCKS cycles with no termination):
//   drop cyc, set err_o, abort the sweep with no UPD, go to WAIT.
//   Beams already written keep their new values.
//  Simultaneous ack with err/rty: err wins over rty, and rty wins over ack.
//  enable_i=0 mid-sweep: finish the current bus transaction, then go to IDLE. No UPD; err_o cleared.
//  busy_o=1 from RD of beam 0 until return to WAIT/IDLE.
//  Reset mid-transaction: cyc/stb drop asynchronously; no partial state is retained.
// TESTING
//  T1 NBEAMS=2, target=100, kp=1.0 (1024), counts 100,100 -> both thresholds written 3FFFF, then UPD dat=1.
//  T2 START_THRESH=1000, count 150, target 100, kp=0.5 (512) -> WR dat=1025. Count 0 -> dat=950.
//  T3 Saturation: thresh 3FFF0, err=+1000, kp=1.0 -> dat=3FFFF. Thresh 10, err=-1000 -> dat=0.
//  T4 Target asserts rty twice then ack on RD -> three identical RD requests, correct threshold written, err_o=0.
//  T5 Beam 1 WR gets err, or no response for 255 cycles -> cyc drops, err_o=1,
//   no UPD, beam 0 value retained, next sweep after the period.
//  T6 PERIOD_CLOCKS=50: measure cycles between beam-0 RD starts = 50.
//   Deassert enable mid-RD -> RD completes, IDLE, busy_o=0.

Source files
------------

// File: rtl/l1_rate_servo_wb_if.sv
// l1_rate_servo_wb_if: classic-cycle Wishbone link from the rate servo to the L1 trigger target
interface l1_rate_servo_wb_if;
  logic cyc;
  logic stb;
  logic we;
  logic [21:0] adr;
  logic [31:0] dat_w;
  logic [3:0] sel;
  logic ack;
  logic err;
  logic rty;
  logic [31:0] dat_r;
  modport master(output cyc, stb, we, adr, dat_w, sel, input ack, err, rty, dat_r);
  modport slave(input cyc, stb, we, adr, dat_w, sel, output ack, err, rty, dat_r);
endinterface

// File: rtl/l1_rate_servo_wb_master.sv
// l1_rate_servo_wb_master: periodic per-beam proportional trigger-threshold servo over Wishbone
module l1_rate_servo_wb_master #(
  parameter int NBEAMS = 2,
  parameter int PERIOD_CLOCKS = 100000000,
  parameter int TIMEOUT_CLOCKS = 255,
  parameter int NFRAC_KP = 10,
  parameter logic [17:0] START_THRESH = 18'h3FFFF,
  parameter logic [21:0] COUNT_BASE = 22'h000100,
  parameter logic [21:0] THRESH_BASE = 22'h000100,
  parameter logic [21:0] UPDATE_ADDR = 22'h000000
) (
  input  logic wb_clk_i,
  input  logic wb_rst_n_i,
  input  logic enable_i,
  input  logic [31:0] target_i,
  input  logic [31:0] kp_i,
  l1_rate_servo_wb_if.master wb,
  output logic busy_o,
  output logic err_o
);
  localparam int BW = NBEAMS > 1 ? $clog2(NBEAMS) : 1;
  localparam int PW = $clog2(PERIOD_CLOCKS + 1);
  localparam int TW = $clog2(TIMEOUT_CLOCKS + 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_RD = 3'd2, S_CALC = 3'd3, S_WR = 3'd4, S_UPD = 3'd5;
  logic [2:0] state;
  logic [BW-1:0] beam;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic [31:0] count;
  logic [17:0] new_thr;
  logic [17:0] thresh [NBEAMS];
  logic cyc;
  logic signed [32:0] err_v;
  logic signed [65:0] prod;
  logic signed [65:0] sum;
  logic [17:0] sat;
  logic period_up;
  logic last;
  logic fail;
  logic rty;
  logic ack_ok;
  logic term;
  // Proportional correction and saturation; the correction is only consumed in CALC
  always_comb begin
    err_v = $signed({1'b0, count}) - $signed({1'b0, target_i});
    prod = 66'(err_v) * 66'($signed({1'b0, kp_i}));
    sum = (prod >>> NFRAC_KP) + $signed({48'b0, thresh[beam]});
    sat = sum[65] ? 18'd0 : (|sum[64:18]) ? 18'h3FFFF : sum[17:0];
  end
  // Termination decode: err beats rty, rty beats ack, any response beats the timeout
  always_comb begin
    period_up = pcnt == PW'(PERIOD_CLOCKS - 1);
    last = beam == BW'(NBEAMS - 1);
    fail = cyc & (wb.err | (!wb.rty & !wb.ack & (tcnt == TW'(TIMEOUT_CLOCKS - 1))));
    rty = cyc & wb.rty & !wb.err;
    ack_ok = cyc & wb.ack & !wb.err & !wb.rty;
    term = fail | rty | ack_ok;
  end
  // Bus outputs are derived from the registered cycle flag so they stay stable for the whole request
  always_comb begin
    wb.cyc = cyc;
    wb.stb = cyc;
    wb.sel = 4'hF;
    wb.we = cyc & (state != S_RD);
    wb.adr = !cyc ? 22'd0 : state == S_RD ? COUNT_BASE + 22'(beam) : state == S_WR ? THRESH_BASE + 22'(beam) : UPDATE_ADDR;
    wb.dat_w = !cyc ? 32'd0 : state == S_WR ? {14'b0, new_thr} : state == S_UPD ? 32'h1 : 32'd0;
    busy_o = state >= S_RD;
  end
  // Sweep sequencer: period pacing, bus request/retry/abort handling and threshold bookkeeping
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state <= S_IDLE;
      beam <= '0;
      pcnt <= '0;
      tcnt <= '0;
      count <= '0;
      new_thr <= '0;
      cyc <= 1'b0;
      err_o <= 1'b0;
      for (int i = 0; i < NBEAMS; i++) thresh[i] <= START_THRESH;
    end else begin
      err_o <= enable_i & (err_o | fail);
      tcnt <= cyc ? tcnt + TW'(1) : '0;
      pcnt <= (state == S_IDLE || (state == S_WAIT && period_up)) ? '0 : period_up ? pcnt : pcnt + PW'(1);
      case (state)
        S_IDLE: state <= enable_i ? S_WAIT : S_IDLE;
        S_WAIT: begin
          beam <= '0;
          state <= !enable_i ? S_IDLE : period_up ? S_RD : S_WAIT;
        end
        S_CALC: begin
          new_thr <= sat;
          state <= enable_i ? S_WR : S_IDLE;
        end
        default: begin
          if (!cyc) begin
            cyc <= enable_i;
            state <= enable_i ? state : S_IDLE;
          end else if (term) begin
            cyc <= 1'b0;
            if (ack_ok && state == S_RD) count <= wb.dat_r;
            if (ack_ok && state == S_WR) thresh[beam] <= new_thr;
            if (ack_ok && state == S_WR && !last) beam <= beam + BW'(1);
            state <= !enable_i ? S_IDLE : fail ? S_WAIT : !ack_ok ? state : state == S_RD ? S_CALC : state == S_WR ? (last ? S_UPD : S_RD) : S_WAIT;
          end
        end
      endcase
    end
  end
endmodule
